// File: rtl/sm4_dec_core.sv
// -----------------------------------------------------------------------------
// sm4_dec_core
// Iterative SM4 block engine. It runs one round per clock and 32 rounds per
// 128-bit block. Round keys are held in a local 32-entry table that the
// key-expansion block writes. The table is read in reverse order (rk31 first)
// to decrypt. The engine recovers the plaintext from the ciphertext that the
// pipelined encryption datapath produces.
//
// Optional feature: when the macro SM4_DEC_ENC_MODE_EN is defined, the input
// i_mode is added. i_mode is sampled when a block is accepted.
// i_mode = 1 selects encryption, with the keys read in forward order.
// i_mode = 0 selects decryption.
//
// Ports:
//   i_clk, i_rst   clock; asynchronous active-high reset
//   i_rk_wr        round-key write strobe (honoured only in IDLE)
//   i_rk_idx       round-key index 0..31, in encryption order
//   i_rk           round-key value
//   i_key_clr      clears the loaded-key mask (IDLE only; wins over i_rk_wr)
//   i_mode         1 = encrypt, 0 = decrypt (only with SM4_DEC_ENC_MODE_EN)
//   i_data         input block {X0,X1,X2,X3}, X0 = [127:96]
//   i_valid        input block valid; accepted when o_ready is high
//   o_ready        engine is idle and every round key is loaded
//   o_data         result block
//   o_valid        result valid; held until i_ready is high
//   i_ready        downstream accepts o_data
//   o_busy         engine is in RUN or DONE
//   o_key_full     all 32 round keys are loaded
// -----------------------------------------------------------------------------
module sm4_dec_core #(
  parameter int unsigned ROUNDS = 32,
  parameter int unsigned CNT_W  = 5
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_rk_wr,
  input  logic [CNT_W-1:0]   i_rk_idx,
  input  logic [31:0]        i_rk,
  input  logic               i_key_clr,
`ifdef SM4_DEC_ENC_MODE_EN
  input  logic               i_mode,
`endif
  input  logic [127:0]       i_data,
  input  logic               i_valid,
  output logic               o_ready,
  output logic [127:0]       o_data,
  output logic               o_valid,
  input  logic               i_ready,
  output logic               o_busy,
  output logic               o_key_full
);

  localparam int unsigned       WORD_W = 32;
  localparam int unsigned       BLK_W  = 4 * WORD_W;
  localparam logic [CNT_W-1:0]  LAST   = CNT_W'(ROUNDS - 1);

  // SM4 S-box. Entry 0 is the most significant byte.
  localparam logic [2047:0] SBOX_ROM = {
    128'hd690e9fecce13db716b614c228fb2c05, 128'h2b679a762abe04c3aa44132649860699,
    128'h9c4250f491ef987a33540b43edcfac62, 128'he4b31ca9c908e89580df94fa758f3fa6,
    128'h4707a7fcf37317ba83593c19e6854fa8, 128'h686b81b27164da8bf8eb0f4b70569d35,
    128'h1e240e5e6358d1a225227c3b01217887, 128'hd40046579fd327524c3602e7a0c4c89e,
    128'heabf8ad240c738b5a3f7f2cef96115a1, 128'he0ae5da49b341a55ad933230f58cb1e3,
    128'h1df6e22e8266ca60c02923ab0d534e6f, 128'hd5db3745defd8e2f03ff6a726d6c5b51,
    128'h8d1baf92bbddbc7f11d95c411f105ad8, 128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
    128'h8969974a0c96777e65b9f109c56ec684, 128'h18f07dec3adc4d2079ee5f3ed7cb3948
  };

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic [7:0] sbox(input logic [7:0] a);
    // Byte a sits at bit offset 8*(255-a); 255-a equals ~a for an 8-bit value.
    return SBOX_ROM[{~a, 3'b000} +: 8];
  endfunction

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [BLK_W-1:0]    x_q, x_d;
  logic [BLK_W-1:0]    data_d;
  logic                valid_d;
  logic [ROUNDS-1:0]   mask_q, mask_d;
  logic                key_we;
  logic [WORD_W-1:0]   rk_tab [ROUNDS];
  logic [CNT_W-1:0]    key_idx;
  logic [WORD_W-1:0]   rk_sel, b, tau, t, x0_new;

`ifdef SM4_DEC_ENC_MODE_EN
  logic                mode_q, mode_d;
  assign key_idx = mode_q ? cnt_q : LAST - cnt_q;
`else
  assign key_idx = LAST - cnt_q;
`endif

  // One round: non-linear tau, then the linear diffusion L.
  assign rk_sel = rk_tab[key_idx];
  assign b      = x_q[95:64] ^ x_q[63:32] ^ x_q[31:0] ^ rk_sel;
  assign tau    = {sbox(b[31:24]), sbox(b[23:16]), sbox(b[15:8]), sbox(b[7:0])};
  assign t      = tau ^ {tau[29:0], tau[31:30]} ^ {tau[21:0], tau[31:22]}
                      ^ {tau[13:0], tau[31:14]} ^ {tau[7:0],  tau[31:8]};
  assign x0_new = x_q[127:96] ^ t;

  assign o_ready = (state_q == IDLE) && o_key_full;
  assign o_busy  = (state_q != IDLE);

  // Next-state and datapath control.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    data_d  = o_data;
    valid_d = o_valid;
    mask_d  = mask_q;
    key_we  = 1'b0;
`ifdef SM4_DEC_ENC_MODE_EN
    mode_d  = mode_q;
`endif
    case (state_q)
      IDLE: begin
        if (i_key_clr) begin
          mask_d = '0;
        end else if (i_rk_wr) begin
          mask_d[i_rk_idx] = 1'b1;
          key_we           = 1'b1;
        end
        if (i_valid && o_ready) begin
          x_d     = i_data;
          cnt_d   = '0;
          state_d = RUN;
`ifdef SM4_DEC_ENC_MODE_EN
          mode_d  = i_mode;
`endif
        end
      end
      RUN: begin
        x_d   = {x_q[95:0], x0_new};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST) begin
          // Output is the word-reversed post-round state.
          data_d  = {x0_new, x_q[31:0], x_q[63:32], x_q[95:64]};
          valid_d = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        if (i_ready) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and datapath registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      x_q        <= '0;
      o_data     <= '0;
      o_valid    <= 1'b0;
      mask_q     <= '0;
      o_key_full <= 1'b0;
`ifdef SM4_DEC_ENC_MODE_EN
      mode_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      x_q        <= x_d;
      o_data     <= data_d;
      o_valid    <= valid_d;
      mask_q     <= mask_d;
      o_key_full <= &mask_d;
`ifdef SM4_DEC_ENC_MODE_EN
      mode_q     <= mode_d;
`endif
    end
  end

  // Round-key table. Its contents are meaningless until the key mask reports them loaded.
  always_ff @(posedge i_clk) begin
    if (key_we) begin
      rk_tab[i_rk_idx] <= i_rk;
    end
  end

endmodule

// File: tb/tb_sm4_dec_core.sv
`timescale 1ns/1ps
module tb_sm4_dec_core;

  localparam logic [127:0] STD_KEY = 128'h0123456789abcdeffedcba9876543210;
  localparam logic [127:0] STD_PT  = 128'h0123456789abcdeffedcba9876543210;
  localparam logic [127:0] STD_CT  = 128'h681edf34d206965e86b3e94f536e4246;

  localparam logic [2047:0] SBOX_HEX = {
    128'hd690e9fecce13db716b614c228fb2c05, 128'h2b679a762abe04c3aa44132649860699,
    128'h9c4250f491ef987a33540b43edcfac62, 128'he4b31ca9c908e89580df94fa758f3fa6,
    128'h4707a7fcf37317ba83593c19e6854fa8, 128'h686b81b27164da8bf8eb0f4b70569d35,
    128'h1e240e5e6358d1a225227c3b01217887, 128'hd40046579fd327524c3602e7a0c4c89e,
    128'heabf8ad240c738b5a3f7f2cef96115a1, 128'he0ae5da49b341a55ad933230f58cb1e3,
    128'h1df6e22e8266ca60c02923ab0d534e6f, 128'hd5db3745defd8e2f03ff6a726d6c5b51,
    128'h8d1baf92bbddbc7f11d95c411f105ad8, 128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
    128'h8969974a0c96777e65b9f109c56ec684, 128'h18f07dec3adc4d2079ee5f3ed7cb3948
  };

  logic         i_clk = 1'b0;
  logic         i_rst = 1'b1;
  logic         i_rk_wr = 1'b0;
  logic [4:0]   i_rk_idx = '0;
  logic [31:0]  i_rk = '0;
  logic         i_key_clr = 1'b0;
`ifdef SM4_DEC_ENC_MODE_EN
  logic         i_mode = 1'b0;
`endif
  logic [127:0] i_data = '0;
  logic         i_valid = 1'b0;
  logic         o_ready;
  logic [127:0] o_data;
  logic         o_valid;
  logic         i_ready = 1'b0;
  logic         o_busy;
  logic         o_key_full;

  sm4_dec_core dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_rk_wr    (i_rk_wr),
    .i_rk_idx   (i_rk_idx),
    .i_rk       (i_rk),
    .i_key_clr  (i_key_clr),
`ifdef SM4_DEC_ENC_MODE_EN
    .i_mode     (i_mode),
`endif
    .i_data     (i_data),
    .i_valid    (i_valid),
    .o_ready    (o_ready),
    .o_data     (o_data),
    .o_valid    (o_valid),
    .i_ready    (i_ready),
    .o_busy     (o_busy),
    .o_key_full (o_key_full)
  );

  always #5 i_clk = ~i_clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  logic [7:0]  sb [256];
  logic [31:0] rk_m [32];

  typedef struct {
    logic [127:0] din;
    logic [127:0] exp;
  } vec_t;
  vec_t vecs [6];

  function automatic logic [31:0] rotl(input logic [31:0] w, input int n);
    return (w << n) | (w >> (32 - n));
  endfunction

  function automatic logic [31:0] tau(input logic [31:0] w);
    return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
  endfunction

  // SM4 key schedule, straight from its definition: K = MK ^ FK, rk_i = K_{i+4}.
  function automatic void expand_key(input logic [127:0] mk);
    logic [31:0] k [36];
    logic [31:0] fk [4];
    logic [31:0] ck, tt;
    fk[0] = 32'ha3b1bac6; fk[1] = 32'h56aa3350; fk[2] = 32'h677d9197; fk[3] = 32'hb27022dc;
    for (int i = 0; i < 4; i++) k[i] = mk[127 - 32*i -: 32] ^ fk[i];
    for (int i = 0; i < 32; i++) begin
      for (int j = 0; j < 4; j++) ck[31 - 8*j -: 8] = 8'(((4*i + j) * 7) % 256);
      tt = tau(k[i+1] ^ k[i+2] ^ k[i+3] ^ ck);
      k[i+4] = k[i] ^ tt ^ rotl(tt, 13) ^ rotl(tt, 23);
      rk_m[i] = k[i+4];
    end
  endfunction

  // Block cipher over the 36-word sequence X0..X35.
  function automatic logic [127:0] model(input logic [127:0] blk, input bit enc);
    logic [31:0] xs [36];
    logic [31:0] tt;
    for (int i = 0; i < 4; i++) xs[i] = blk[127 - 32*i -: 32];
    for (int i = 0; i < 32; i++) begin
      tt = tau(xs[i+1] ^ xs[i+2] ^ xs[i+3] ^ rk_m[enc ? i : 31 - i]);
      xs[i+4] = xs[i] ^ tt ^ rotl(tt, 2) ^ rotl(tt, 10) ^ rotl(tt, 18) ^ rotl(tt, 24);
    end
    return {xs[35], xs[34], xs[33], xs[32]};
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic load_key(input int idx, input logic [31:0] val);
    i_rk_wr  = 1'b1;
    i_rk_idx = 5'(idx);
    i_rk     = val;
    tick();
    i_rk_wr  = 1'b0;
  endtask

  task automatic load_all(input int skip);
    for (int i = 0; i < 32; i++) if (i != skip) load_key(i, rk_m[i]);
  endtask

  task automatic start_block(input logic [127:0] din, input logic mode);
    int guard;
    guard = 0;
    while (!o_ready && guard < 100) begin
      tick();
      guard++;
    end
    check("ready_before_accept", 128'(o_ready), 128'd1);
    i_data  = din;
`ifdef SM4_DEC_ENC_MODE_EN
    i_mode  = mode;
`endif
    i_valid = 1'b1;
    tick();
    i_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!o_valid && lat < 100) begin
      tick();
      lat++;
    end
  endtask

  task automatic consume(input int hold);
    repeat (hold) tick();
    i_ready = 1'b1;
    tick();
    i_ready = 1'b0;
  endtask

  task automatic run_block(input logic [127:0] din, input logic mode, input int hold,
                           output logic [127:0] dout, output int lat);
    start_block(din, mode);
    wait_valid(lat);
    dout = o_data;
    consume(hold);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] dout, ct;
    int lat;
    bit saw_valid, saw_ready, stable;

    for (int i = 0; i < 256; i++) sb[i] = SBOX_HEX[2047 - 8*i -: 8];
    expand_key(STD_KEY);

    // Reset state
    repeat (3) tick();
    check("rst_o_data", o_data, 128'd0);
    check("rst_o_valid", 128'(o_valid), 128'd0);
    check("rst_o_ready", 128'(o_ready), 128'd0);
    check("rst_o_busy", 128'(o_busy), 128'd0);
    check("rst_o_key_full", 128'(o_key_full), 128'd0);
    i_rst = 1'b0;
    tick();

    // Key gating: index 17 missing
    load_all(17);
    check("gate_key_full", 128'(o_key_full), 128'd0);
    check("gate_ready", 128'(o_ready), 128'd0);
    i_data = STD_CT;
    i_valid = 1'b1;
    repeat (4) tick();
    check("gate_not_busy", 128'(o_busy), 128'd0);
    i_valid = 1'b0;
    load_key(17, rk_m[17]);
    check("gate_ready_after_17", 128'(o_ready), 128'd1);
    check("gate_key_full_after_17", 128'(o_key_full), 128'd1);

    // Table-driven vectors
    vecs[0] = '{STD_CT, STD_PT};
    for (int i = 1; i < 6; i++) begin
      vecs[i].din = rand128();
      vecs[i].exp = model(vecs[i].din, 1'b0);
    end
    for (int i = 0; i < 6; i++) begin
      run_block(vecs[i].din, 1'b0, i, dout, lat);
      check($sformatf("vec%0d_data", i), dout, vecs[i].exp);
      check($sformatf("vec%0d_latency", i), 128'(lat), 128'd32);
      check($sformatf("vec%0d_valid_cleared", i), 128'(o_valid), 128'd0);
      check($sformatf("vec%0d_idle", i), 128'(o_busy), 128'd0);
    end

    // Backpressure in DONE with a competing input
    start_block(STD_CT, 1'b0);
    wait_valid(lat);
    i_data = rand128();
    i_valid = 1'b1;
    stable = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (!o_valid || o_data !== STD_PT || o_ready || !o_busy) stable = 1'b0;
      tick();
    end
    check("bp_stable_hold", 128'(stable), 128'd1);
    check("bp_data", o_data, STD_PT);
    i_valid = 1'b0;
    consume(0);
    check("bp_released", 128'(o_valid), 128'd0);
    check("bp_idle", 128'(o_busy), 128'd0);
    check("bp_ready", 128'(o_ready), 128'd1);

    // Key writes and clear during RUN are ignored
    start_block(STD_CT, 1'b0);
    repeat (4) tick();
    load_key(31, 32'h0);
    load_key(0, 32'h0);
    i_key_clr = 1'b1;
    tick();
    i_key_clr = 1'b0;
    wait_valid(lat);
    check("run_wr_data", o_data, STD_PT);
    check("run_wr_key_full", 128'(o_key_full), 128'd1);
    consume(0);
    run_block(STD_CT, 1'b0, 0, dout, lat);
    check("run_wr_table_kept", dout, STD_PT);

    // Asynchronous reset at round 15
    start_block(STD_CT, 1'b0);
    repeat (15) tick();
    i_rst = 1'b1;
    #1;
    check("mid_rst_valid", 128'(o_valid), 128'd0);
    check("mid_rst_busy", 128'(o_busy), 128'd0);
    check("mid_rst_key_full", 128'(o_key_full), 128'd0);
    check("mid_rst_ready", 128'(o_ready), 128'd0);
    tick();
    i_rst = 1'b0;
    i_data = STD_CT;
    i_valid = 1'b1;
    saw_valid = 1'b0;
    saw_ready = 1'b0;
    for (int c = 0; c < 40; c++) begin
      saw_valid |= o_valid;
      saw_ready |= o_ready;
      tick();
    end
    i_valid = 1'b0;
    check("post_rst_no_valid", 128'(saw_valid), 128'd0);
    check("post_rst_no_ready", 128'(saw_ready), 128'd0);
    load_all(-1);
    check("reload_ready", 128'(o_ready), 128'd1);
    run_block(STD_CT, 1'b0, 0, dout, lat);
    check("reload_data", dout, STD_PT);

`ifdef SM4_DEC_ENC_MODE_EN
    // Encryption mode and round trips
    run_block(STD_PT, 1'b1, 0, dout, lat);
    check("enc_std", dout, STD_CT);
    check("enc_latency", 128'(lat), 128'd32);
    for (int i = 0; i < 1000; i++) begin
      vecs[0].din = rand128();
      run_block(vecs[0].din, 1'b1, 0, ct, lat);
      check($sformatf("rt%0d_enc", i), ct, model(vecs[0].din, 1'b1));
      run_block(ct, 1'b0, 0, dout, lat);
      check($sformatf("rt%0d_dec", i), dout, vecs[0].din);
    end
`else
    // Random decryption against the model with random backpressure
    for (int i = 0; i < 200; i++) begin
      vecs[0].din = rand128();
      run_block(vecs[0].din, 1'b0, int'($urandom_range(0, 3)), dout, lat);
      check($sformatf("rnd%0d_data", i), dout, model(vecs[0].din, 1'b0));
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sm4_dec_core.md
Name: sm4_dec_core

Overview:
- Iterative SM4 decryption engine; one round per clock, 32 rounds per 128-bit block.
- Holds a 32-entry round-key table written by the key-expansion block over an indexed write port.
- Applies the round keys in reverse order (rk31 first) and performs the final reverse word transform.
- Sits downstream of key expansion, opposite the pipelined encryption datapath; it recovers plaintext from that datapath's ciphertext.

Parameters:
- ROUNDS, 32, number of rounds per block; fixed for SM4, and only 32 is legal.
- CNT_W, 5, width of the round counter and key index.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset, asynchronous, active-high
- i_rk_wr  in  1  round-key write strobe
- i_rk_idx  in  5  round-key index 0..31, in encryption order
- i_rk  in  32  round-key value
- i_key_clr  in  1  clears the loaded-key mask
- i_data  in  128  ciphertext block {X0,X1,X2,X3}, X0 = [127:96]
- i_valid  in  1  input block valid
- o_ready  out  1  engine can accept a block
- o_data  out  128  plaintext block
- o_valid  out  1  output valid; held until consumed
- i_ready  in  1  downstream accepts o_data
- o_busy  out  1  high in RUN or DONE
- o_key_full  out  1  all 32 round keys are loaded

Behaviour:
- Reset values: o_data = 0, o_valid = 0, o_ready = 0, o_busy = 0, o_key_full = 0, key mask = 0, state = IDLE, counter = 0. The key table contents are don't-care after reset.
- Key table:
  - In IDLE, an i_rk_wr pulse writes table[i_rk_idx] and sets mask[i_rk_idx].
  - In RUN or DONE, writes are ignored; the table and mask are unchanged.
  - In IDLE, i_key_clr zeroes the mask. If i_key_clr and i_rk_wr occur in the same cycle, the clear wins.
  - o_key_full = &mask, registered.
- o_ready = (state == IDLE) && o_key_full, combinational from registers.
- FSM IDLE:
  - When i_valid && o_ready, latch i_data into the state registers X0..X3, set the counter to 0, and go to RUN.
  - i_valid while o_ready = 0 is not accepted. The source must hold i_valid until it sees o_ready.
- FSM RUN, each clock:
  - k = table[31 - cnt].
  - B = X1^X2^X3^k.
  - tau = four parallel SM4 S-box lookups on the bytes of B (combinational ROM).
  - T = tau ^ (tau<<<2) ^ (tau<<<10) ^ (tau<<<18) ^ (tau<<<24).
  - Next state = {X1, X2, X3, X0^T}; cnt increments.
  - When cnt == 31, the round is completed and o_data <= {X3', X2', X1', X0'} (reverse of the post-round state). o_valid is set and the FSM goes to DONE.
- Latency: o_valid rises exactly 32 clock edges after the accept edge.
- FSM DONE:
  - o_valid and o_data are held stable while i_ready = 0.
  - On i_valid... no: on o_valid && i_ready, o_valid clears next edge and the FSM returns to IDLE.
  - A new block can be accepted at the earliest one cycle after the output handshake. Throughput is 1 block per 34 cycles with i_ready tied high.
- Asynchronous reset mid-RUN or in DONE aborts the block: no o_valid, and all outputs return to their reset values.
- i_key_clr outside IDLE is ignored.

Optional Feature:
- Macro SM4_DEC_ENC_MODE_EN.
- When defined:
  - Adds input i_mode (1 bit), sampled at the accept edge.
  - i_mode = 1 selects encryption: k = table[cnt], forward order.
  - i_mode = 0 selects decryption, as above.
  - Mode is held internally for the block and does not change latency.
- When undefined: no i_mode port, decryption only.

Test Plan:
- Standard vector: load key 0123456789abcdeffedcba9876543210 expansion (rk0 = f12186f9 … rk31 = 9124a012), then i_data = 681edf34d206965e86b3e94f536e4246 → o_data = 0123456789abcdeffedcba9876543210, with o_valid exactly 32 edges after accept.
- Key gating: load only 31 keys with index 17 missing → o_key_full = 0, o_ready = 0, and i_valid is ignored. Write index 17 → o_ready = 1 the next cycle.
- Backpressure: i_ready = 0 for 10 cycles in DONE → o_data is stable and o_valid = 1 throughout. A second i_valid during this time is not accepted, and o_ready = 0.
- Key write during RUN: write rk31 = 0 mid-block → the result is still the correct plaintext and table[31] keeps its old value. i_key_clr during RUN → mask unchanged.
- Reset at round 15 → o_valid never asserts, o_busy = 0, o_key_full = 0, and o_ready stays 0 until the keys are reloaded.
- With SM4_DEC_ENC_MODE_EN and i_mode = 1: plaintext 0123456789abcdeffedcba9876543210 → o_data = 681edf34d206965e86b3e94f536e4246. Encrypting then decrypting 1000 random blocks must round-trip to the original data.
